// File: rtl/cr_native_types.sv
// Shared datapath types: the stats index enumeration used by every CCEIP/CDDIP
// sub-block when it raises a statistics event.
package cr_native_types;

  typedef enum logic [9:0] {
    ISF_IN_TOTAL      = 10'd0,
    ISF_OUT_TOTAL     = 10'd1,
    LZ77C_IN_BYTES    = 10'd256,
    LZ77D_STALL_TOTAL = 10'd400,
    HUF_SYM_TOTAL     = 10'd720,
    OSF_OUT_BYTES     = 10'd896,
    OSF_STALL_TOTAL   = 10'd897,
    STATS_LAST        = 10'd1023
  } cceip_stats_e;

endpackage

// File: rtl/cr_stats_pkg.sv
// Types and sizes shared by the statistics collector and its arbiter.
package cr_stats_pkg;

  import cr_native_types::*;

  localparam int STAT_W = $bits(cceip_stats_e);
  localparam int CNT_W  = 48;
  localparam int INC_W  = 8;
  localparam int N_REQ  = 4;
  localparam int DEPTH  = 1 << STAT_W;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } stats_fsm_e;

  typedef struct packed {
    logic               valid;
    logic               is_host;
    logic               clr;
    cceip_stats_e       addr;
    logic [INC_W-1:0]   inc;
  } stats_op_t;

endpackage

// File: rtl/cr_stats_rr_arb.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer moves past the winner whenever a grant is issued.
module cr_stats_rr_arb #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % N_REQ);
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        ptr_d      = PTR_W'((int'(idx) + 1) % N_REQ);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cr_stats_collector.sv
// Statistics collector: arbitrates requester events and host reads into a
// two-stage read-modify-write pipeline over a zero-initialised counter RAM.
module cr_stats_collector #(
  parameter int N_REQ  = cr_stats_pkg::N_REQ,
  parameter int STAT_W = cr_stats_pkg::STAT_W,
  parameter int CNT_W  = cr_stats_pkg::CNT_W,
  parameter int INC_W  = cr_stats_pkg::INC_W,
  parameter int DEPTH  = cr_stats_pkg::DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        stat_valid,
  input  logic [N_REQ*STAT_W-1:0] stat_id,
  input  logic [N_REQ*INC_W-1:0]  stat_inc,
  output logic [N_REQ-1:0]        stat_ready,
  input  logic                    host_rd_req,
  input  logic [STAT_W-1:0]       host_rd_addr,
  input  logic                    host_rd_clr,
  output logic                    host_rd_ack,
  output logic [CNT_W-1:0]        host_rd_data,
  output logic                    init_done
);

  import cr_native_types::*;
  import cr_stats_pkg::*;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [INC_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W + 1 - INC_W){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  stats_fsm_e        state_q, state_d;
  logic [STAT_W-1:0] init_addr_q, init_addr_d;
  logic              init_done_q;

  logic              run;
  logic              host_busy;
  logic              host_sel;
  logic [N_REQ-1:0]  gnt;

  stats_op_t         op_p0_d;
  stats_op_t         op_p1_q;
  logic [CNT_W-1:0]  mem [DEPTH];
  logic [CNT_W-1:0]  rd_data_p1_q;
  logic [CNT_W-1:0]  fwd_val_p1_q;
  logic              fwd_hit_p1_q;
  logic [CNT_W-1:0]  cur_p1, new_p1;
  logic              we_p1;

  logic              we;
  logic [STAT_W-1:0] waddr;
  logic [CNT_W-1:0]  wdata;

  logic              ack_q;
  logic [CNT_W-1:0]  rd_out_q;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + 1'b1;
      if (init_addr_q == STAT_W'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_done_q <= (state_q == ST_RUN);
    end
  end

  // Stage A (p0): select host or one requester and issue the RAM read.
  // The host stays blocked through its ack cycle so a held request is not re-taken.
  assign run       = (state_q == ST_RUN) && !rst;
  assign host_busy = (op_p1_q.valid && op_p1_q.is_host) || ack_q;
  assign host_sel  = run && host_rd_req && !host_busy;

  cr_stats_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (stat_valid),
    .en_i  (run && !host_sel),
    .gnt_o (gnt)
  );

  assign stat_ready = gnt;

  always_comb begin
    op_p0_d = '0;
    if (host_sel) begin
      op_p0_d.valid   = 1'b1;
      op_p0_d.is_host = 1'b1;
      op_p0_d.clr     = host_rd_clr;
      op_p0_d.addr    = cceip_stats_e'(host_rd_addr);
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i]) begin
          op_p0_d.valid = 1'b1;
          op_p0_d.addr  = cceip_stats_e'(stat_id[i*STAT_W +: STAT_W]);
          op_p0_d.inc   = stat_inc[i*INC_W +: INC_W];
        end
      end
    end
  end

  // Stage B (p1): merge forwarded data, compute the update and write back.
  assign cur_p1 = fwd_hit_p1_q ? fwd_val_p1_q : rd_data_p1_q;
  assign new_p1 = op_p1_q.is_host ? '0 : sat_add(cur_p1, op_p1_q.inc);
  assign we_p1  = op_p1_q.valid && (!op_p1_q.is_host || op_p1_q.clr);

  always_comb begin
    we    = 1'b0;
    waddr = op_p1_q.addr;
    wdata = new_p1;
    if (state_q == ST_INIT) begin
      we    = !rst;
      waddr = init_addr_q;
      wdata = '0;
    end else begin
      we    = we_p1 && !rst;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rd_data_p1_q <= mem[op_p0_d.addr];
    fwd_val_p1_q <= new_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_p1_q.valid <= 1'b0;
      fwd_hit_p1_q  <= 1'b0;
      ack_q         <= 1'b0;
      rd_out_q      <= '0;
    end else begin
      op_p1_q       <= op_p0_d;
      fwd_hit_p1_q  <= we_p1 && op_p0_d.valid && (op_p1_q.addr == op_p0_d.addr);
      ack_q         <= op_p1_q.valid && op_p1_q.is_host;
      if (op_p1_q.valid && op_p1_q.is_host) begin
        rd_out_q <= cur_p1;
      end
    end
  end

  assign host_rd_ack  = ack_q;
  assign host_rd_data = rd_out_q;
  assign init_done    = init_done_q;

endmodule

// File: tb/tb_cr_stats_collector.sv
// Bench for cr_stats_collector: a 48-bit and a 10-bit counter instance share
// stimulus and are checked each cycle against a grant-order counter model.
module tb_cr_stats_collector;

  localparam int N     = 4;
  localparam int SW    = 10;
  localparam int IW    = 8;
  localparam int DEPTH = 1024;
  localparam longint unsigned MAX48 = 64'hFFFF_FFFF_FFFF;
  localparam longint unsigned MAX10 = 64'd1023;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    stat_valid;
  logic [N*SW-1:0] stat_id;
  logic [N*IW-1:0] stat_inc;
  logic [N-1:0]    stat_ready, s_ready;
  logic            host_rd_req;
  logic [SW-1:0]   host_rd_addr;
  logic            host_rd_clr;
  logic            host_rd_ack, s_ack;
  logic [47:0]     host_rd_data;
  logic [9:0]      s_data;
  logic            init_done, s_init;

  cr_stats_collector u_dut (
    .clk(clk), .rst(rst), .stat_valid(stat_valid), .stat_id(stat_id),
    .stat_inc(stat_inc), .stat_ready(stat_ready), .host_rd_req(host_rd_req),
    .host_rd_addr(host_rd_addr), .host_rd_clr(host_rd_clr),
    .host_rd_ack(host_rd_ack), .host_rd_data(host_rd_data), .init_done(init_done)
  );

  cr_stats_collector #(.CNT_W(10)) u_dut_s (
    .clk(clk), .rst(rst), .stat_valid(stat_valid), .stat_id(stat_id),
    .stat_inc(stat_inc), .stat_ready(s_ready), .host_rd_req(host_rd_req),
    .host_rd_addr(host_rd_addr), .host_rd_clr(host_rd_clr),
    .host_rd_ack(s_ack), .host_rd_data(s_data), .init_done(s_init)
  );

  int n_chk  = 0;
  int n_fail = 0;

  longint unsigned cnt48 [DEPTH];
  longint unsigned cnt10 [DEPTH];
  bit              pend_vld [2];
  longint unsigned pend48 [2];
  longint unsigned pend10 [2];
  longint unsigned hold48, hold10;
  bit              host_want, host_clr, inflight, started;
  int              host_addr, ptr, n_edges;
  bit              nx_rst;
  logic [N-1:0]    nx_valid;
  int              nx_id [N];
  int              nx_inc [N];
  int              pool [6] = '{720, 896, 897, 100, 5, 1023};

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [N-1:0]    exp_rdy;
    bit              run, found;
    int              i;
    longint unsigned v;
    @(negedge clk);
    if (started) begin
      chk_eq("ack", 64'(host_rd_ack), 64'(pend_vld[0]));
      chk_eq("ack_s", 64'(s_ack), 64'(pend_vld[0]));
      if (pend_vld[0]) begin
        hold48    = pend48[0];
        hold10    = pend10[0];
        host_want = 1'b0;
        inflight  = 1'b0;
      end
      chk_eq("rdata", 64'(host_rd_data), hold48);
      chk_eq("rdata_s", 64'(s_data), hold10);
      if (n_edges <= 1 || n_edges == DEPTH || n_edges == DEPTH + 1) begin
        chk_eq("init_done", 64'(init_done), 64'(n_edges >= DEPTH + 1));
        chk_eq("init_done_s", 64'(s_init), 64'(n_edges >= DEPTH + 1));
      end
    end
    pend_vld[0] = pend_vld[1]; pend48[0] = pend48[1]; pend10[0] = pend10[1];
    pend_vld[1] = 1'b0;

    rst          = nx_rst;
    stat_valid   = nx_valid;
    for (int k = 0; k < N; k++) begin
      stat_id[k*SW +: SW]  = nx_id[k][SW-1:0];
      stat_inc[k*IW +: IW] = nx_inc[k][IW-1:0];
    end
    host_rd_req  = host_want;
    host_rd_addr = host_addr[SW-1:0];
    host_rd_clr  = host_clr;
    #1;

    run     = started && !nx_rst && (n_edges >= DEPTH);
    exp_rdy = '0;
    if (run && host_rd_req && !inflight) begin
      inflight    = 1'b1;
      pend_vld[1] = 1'b1;
      pend48[1]   = cnt48[host_addr];
      pend10[1]   = cnt10[host_addr];
      if (host_clr) begin
        cnt48[host_addr] = 0;
        cnt10[host_addr] = 0;
      end
    end else if (run) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        i = (ptr + k) % N;
        if (!found && nx_valid[i]) begin
          found      = 1'b1;
          exp_rdy[i] = 1'b1;
          ptr        = (i + 1) % N;
          v = cnt48[nx_id[i]] + longint'(nx_inc[i]);
          cnt48[nx_id[i]] = (v > MAX48) ? MAX48 : v;
          v = cnt10[nx_id[i]] + longint'(nx_inc[i]);
          cnt10[nx_id[i]] = (v > MAX10) ? MAX10 : v;
        end
      end
    end
    if (started) begin
      chk_eq("ready", 64'(stat_ready), 64'(exp_rdy));
      chk_eq("ready_s", 64'(s_ready), 64'(exp_rdy));
    end

    if (nx_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        cnt48[k] = 0;
        cnt10[k] = 0;
      end
      pend_vld[0] = 1'b0; pend_vld[1] = 1'b0;
      hold48 = 0; hold10 = 0;
      host_want = 1'b0; inflight = 1'b0;
      ptr = 0; n_edges = 0; started = 1'b1;
    end else begin
      n_edges++;
    end
    @(posedge clk);
  endtask

  task automatic host_read(input int a, input bit c);
    host_want = 1'b1;
    host_addr = a;
    host_clr  = c;
    for (int k = 0; k < 16 && host_want; k++) tick();
    if (host_want) begin
      chk_eq("host_timeout", 64'(host_want), 64'd0);
      host_want = 1'b0;
    end
    #1;
  endtask

  task automatic rand_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      nx_valid = N'($urandom);
      for (int k = 0; k < N; k++) begin
        nx_id[k]  = ($urandom % 4 == 0) ? int'($urandom % DEPTH) : pool[$urandom % 6];
        nx_inc[k] = ($urandom % 5 == 0) ? 0 : int'($urandom % 256);
      end
      if (!host_want && ($urandom % 6 == 0)) begin
        host_want = 1'b1;
        host_addr = pool[$urandom % 6];
        host_clr  = 1'($urandom % 2);
      end
      tick();
    end
    nx_valid = '0;
    for (int k = 0; k < 16 && host_want; k++) tick();
    repeat (3) tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    started = 1'b0; host_want = 1'b0; host_clr = 1'b0; host_addr = 0;
    inflight = 1'b0; ptr = 0; n_edges = 0; hold48 = 0; hold10 = 0;
    pend_vld[0] = 1'b0; pend_vld[1] = 1'b0;
    nx_rst = 1'b1; nx_valid = '0;
    for (int k = 0; k < N; k++) begin nx_id[k] = 0; nx_inc[k] = 0; end

    repeat (2) tick();
    nx_rst = 1'b0;
    repeat (DEPTH + 2) tick();
    host_read(400, 1'b0);
    chk_eq("rd400", 64'(host_rd_data), 64'd0);

    nx_valid = 4'b0001; nx_id[0] = 720; nx_inc[0] = 3;
    repeat (5) tick();
    nx_valid = '0;
    host_read(720, 1'b0);
    chk_eq("rd720", 64'(host_rd_data), 64'd15);

    nx_valid = 4'b1111;
    for (int k = 0; k < N; k++) begin nx_id[k] = 100 + k; nx_inc[k] = 1; end
    repeat (8) tick();
    nx_valid = '0;
    for (int k = 0; k < N; k++) begin
      host_read(100 + k, 1'b0);
      chk_eq("rd_rr", 64'(host_rd_data), 64'd2);
    end

    nx_valid = 4'b0001; nx_id[0] = 896; nx_inc[0] = 255;
    repeat (6) tick();
    nx_inc[0] = 1;
    tick();
    nx_valid = '0;
    host_read(896, 1'b0);
    chk_eq("rd896", 64'(host_rd_data), 64'd1531);
    chk_eq("rd896_sat", 64'(s_data), 64'd1023);

    nx_valid = 4'b0001; nx_id[0] = 897; nx_inc[0] = 7;
    tick();
    nx_valid = '0;
    repeat (2) tick();
    host_want = 1'b1; host_addr = 897; host_clr = 1'b1;
    nx_valid = 4'b0001; nx_id[0] = 897; nx_inc[0] = 2;
    repeat (2) tick();
    nx_valid = '0;
    for (int k = 0; k < 16 && host_want; k++) tick();
    #1;
    chk_eq("rd897_clr", 64'(host_rd_data), 64'd7);
    host_read(897, 1'b0);
    chk_eq("rd897_after", 64'(host_rd_data), 64'd2);
    chk_eq("rd897_after_s", 64'(s_data), 64'd2);

    rand_phase(1200);

    nx_valid = 4'b0010; nx_id[1] = 50; nx_inc[1] = 5;
    tick();
    nx_valid = '0;
    host_want = 1'b1; host_addr = 50; host_clr = 1'b0;
    tick();
    nx_valid = 4'b0001; nx_id[0] = 51; nx_inc[0] = 9;
    nx_rst = 1'b1;
    repeat (2) tick();
    nx_rst = 1'b0; nx_valid = '0;
    repeat (DEPTH + 2) tick();
    host_read(50, 1'b0);
    chk_eq("rd50_reinit", 64'(host_rd_data), 64'd0);
    host_read(720, 1'b0);
    chk_eq("rd720_reinit", 64'(host_rd_data), 64'd0);
    host_read(896, 1'b0);
    chk_eq("rd896_reinit_s", 64'(s_data), 64'd0);

    rand_phase(600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
